jk_bank_driver: RTL and testbench
=================================

Name: jk_bank_driver

Overview:
- Driver end of the JK flip-flop interface: takes word-level write requests and generates per-bit J/K excitation for an external bank of WIDTH JK flip-flops.
- Reads the bank's Q outputs back and confirms each write, retrying on mismatch.
- Sits between control logic, which issues load/set/clear/toggle commands, and the flip-flop bank, which is the register being written.

Parameters:
- WIDTH, 8, number of JK flip-flops in the driven bank.
- MAX_RETRY, 2, re-drive attempts after the first failed verify before err is raised; range 0..7.

Ports:
- clk  input  1  rising-edge clock, shared with the flip-flop bank.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  driver can accept a request.
- req_op  input  2  00 LOAD, 01 SET, 10 CLR, 11 TOGGLE.
- req_data  input  WIDTH  LOAD: target word; SET/CLR/TOGGLE: bit mask.
- q_fb  input  WIDTH  Q outputs of the flip-flop bank.
- j  output  WIDTH  J inputs of the bank (registered).
- k  output  WIDTH  K inputs of the bank (registered).
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse: write verified.
- err  output  1  one-cycle pulse: write failed after retries.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, j=k=0, done=err=0, busy=0, retry count=0. req_ready=0 while reset is high.
- Handshake: req_ready = (state==IDLE) && !reset. A transfer occurs on a clock edge with req_valid && req_ready. Requests presented while busy are not accepted and are not lost; the requester holds them.
- Excitation, computed from the q_fb snapshot at accept time:
  - LOAD: per bit, q==t gives J=0,K=0; q=0,t=1 gives J=1,K=0; q=1,t=0 gives J=0,K=1. Don't-cares resolve to 0. Expected = req_data.
  - SET: J=mask, K=0. Expected = q|mask.
  - CLR: J=0, K=mask. Expected = q&~mask.
  - TOGGLE: J=K=mask. Expected = q^mask.
- FSM IDLE -> DRIVE -> VERIFY -> {RESP_OK | DRIVE | RESP_ERR} -> IDLE:
  - IDLE: on transfer, latch expected, compute j/k into registers, go to DRIVE.
  - DRIVE (exactly 1 cycle): j/k hold the excitation. The bank updates on the edge ending DRIVE. j/k return to 0 on that same edge.
  - VERIFY: j=k=0. Compare q_fb against expected.
    - Match: go to RESP_OK.
    - Mismatch and retry<MAX_RETRY: retry++, recompute LOAD-style excitation from current q_fb toward expected, go to DRIVE.
    - Mismatch and retry==MAX_RETRY: go to RESP_ERR.
  - RESP_OK: done=1 for one cycle, then IDLE. RESP_ERR: err=1 for one cycle, then IDLE. The retry count clears on leaving either state.
- Latency, good path: accept edge = cycle 0, DRIVE = cycle 1, VERIFY = cycle 2, done high in cycle 3, req_ready high again in cycle 4. Each retry adds 2 cycles.
- j/k are nonzero only in DRIVE. A zero mask, or a LOAD equal to the current Q, still runs the full sequence with j=k=0 and completes with done.
- done and err are never high together and are never high outside RESP_*.
- Reset mid-operation: at the reset edge j/k go to 0, state goes to IDLE, and no done/err is issued for the aborted request.
- Width rules: all vectors are exactly WIDTH bits. The retry counter is 3 bits.

Decomposition:
- Package jk_pkg holds:
  - op_e enum (LOAD, SET, CLR, TOGGLE)
  - state_e enum (IDLE, DRIVE, VERIFY, RESP_OK, RESP_ERR)
  - JK_HOLD/JK_SET/JK_RST/JK_TOG 2-bit constants
  - function expected_next(op, q, data)
- Sub-module jk_excite: purely combinational. Inputs op, q, data; outputs j, k, expected; parameterised by WIDTH.
- The testbench instantiates WIDTH jk_flipflop instances as the bank model, sharing clk and reset.

Test Plan:
- Bank at 0x0F, LOAD 0xF0 -> in DRIVE j=0xF0, k=0x0F; q_fb=0xF0 in VERIFY; done in cycle 3; err=0.
- Bank at 0x00, SET 0x81, then CLR 0x01 -> first write j=0x81, k=0x00, Q=0x81, done. Second write j=0x00, k=0x01, Q=0x80, done.
- Bank at 0x5A, TOGGLE 0xFF -> j=k=0xFF for exactly one cycle; Q=0xA5; done. TOGGLE 0x00 -> j=k=0 throughout; Q stays 0xA5; done.
- Bit 3 of q_fb forced to 0, LOAD 0x08, MAX_RETRY=2 -> 3 DRIVE cycles each with j=0x08; err pulse in cycle 7; done never asserted; req_ready high in cycle 8.
- req_valid held high with back-to-back LOAD 0x11 then LOAD 0x22 -> second request accepted only in cycle 4 (req_ready); Q=0x11 then 0x22; two done pulses.
- reset asserted during DRIVE of LOAD 0xFF from 0x00 -> j=k=0 after the reset edge; no done/err; busy=0; req_ready=1 in the first cycle after reset deasserts.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and per-bit JK excitation helpers for the flip-flop bank driver.
// Purely declarative: no state, no latency, no flow control.
package jk_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_SET    = 2'b01,
        OP_CLR    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRIVE    = 3'd1,
        ST_VERIFY   = 3'd2,
        ST_RESP_OK  = 3'd3,
        ST_RESP_ERR = 3'd4
    } state_e;

    // Encoded as {J, K}.
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_TOG  = 2'b11;

    function automatic logic [1:0] jk_pair(input op_e op, input logic q, input logic d);
        logic [1:0] r;
        r = JK_HOLD;
        case (op)
            OP_LOAD:   r = (q == d) ? JK_HOLD : (d ? JK_SET : JK_RST);
            OP_SET:    r = d ? JK_SET : JK_HOLD;
            OP_CLR:    r = d ? JK_RST : JK_HOLD;
            OP_TOGGLE: r = d ? JK_TOG : JK_HOLD;
            default:   r = JK_HOLD;
        endcase
        return r;
    endfunction

    function automatic logic expected_next(input op_e op, input logic q, input logic d);
        logic r;
        r = q;
        case (op)
            OP_LOAD:   r = d;
            OP_SET:    r = q | d;
            OP_CLR:    r = q & ~d;
            OP_TOGGLE: r = q ^ d;
            default:   r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational J/K excitation and expected next Q for a word-wide JK bank.
// Zero latency; no flow control.
module jk_excite
    import jk_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic [WIDTH-1:0] expected_o
);

    always_comb begin
        j_o        = '0;
        k_o        = '0;
        expected_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            logic [1:0] pair;
            pair          = jk_pair(op_i, q_i[i], data_i[i]);
            j_o[i]        = pair[1];
            k_o[i]        = pair[0];
            expected_o[i] = expected_next(op_i, q_i[i], data_i[i]);
        end
    end

endmodule

// File: rtl/jk_flipflop.sv
// Single JK flip-flop with synchronous active-high reset; models one bank cell.
// One-cycle update; no flow control.
module jk_flipflop (
    input  logic clk,
    input  logic reset,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_o <= 1'b0;
        end else begin
            case ({j_i, k_i})
                2'b10:   q_o <= 1'b1;
                2'b01:   q_o <= 1'b0;
                2'b11:   q_o <= ~q_o;
                default: q_o <= q_o;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives J/K of an external JK bank for word writes, verifies Q, retries on mismatch.
// Good path: done 3 cycles after accept, +2 per retry; req_ready low whenever not IDLE.
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [2:0]       retry_q, retry_d;

    op_e              ex_op;
    logic [WIDTH-1:0] ex_data;
    logic [WIDTH-1:0] ex_j;
    logic [WIDTH-1:0] ex_k;
    logic [WIDTH-1:0] ex_exp;

    // One excitation block serves both the initial command and the LOAD-style retry.
    jk_excite #(.WIDTH(WIDTH)) u_excite (
        .op_i       (ex_op),
        .q_i        (q_fb),
        .data_i     (ex_data),
        .j_o        (ex_j),
        .k_o        (ex_k),
        .expected_o (ex_exp)
    );

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign j         = j_q;
    assign k         = k_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_RESP_OK);
    assign err       = (state_q == ST_RESP_ERR);

    always_comb begin
        state_d = state_q;
        j_d     = '0;
        k_d     = '0;
        exp_d   = exp_q;
        retry_d = retry_q;
        ex_op   = op_e'(req_op);
        ex_data = req_data;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    j_d     = ex_j;
                    k_d     = ex_k;
                    exp_d   = ex_exp;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_d = ST_VERIFY;
            end
            ST_VERIFY: begin
                ex_op   = OP_LOAD;
                ex_data = exp_q;
                if (q_fb == exp_q) begin
                    state_d = ST_RESP_OK;
                end else if (retry_q < RETRY_LIMIT) begin
                    retry_d = retry_q + 3'd1;
                    j_d     = ex_j;
                    k_d     = ex_k;
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_RESP_ERR;
                end
            end
            ST_RESP_OK, ST_RESP_ERR: begin
                retry_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                retry_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            j_q     <= '0;
            k_q     <= '0;
            exp_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
            exp_q   <= exp_d;
            retry_q <= retry_d;
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench: jk_bank_driver against a bank of jk_flipflop cells with optional stuck-at-0 feedback bits.
module tb_jk_bank_driver;

    localparam int W = 8;
    localparam int TR = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_data;
    logic [W-1:0] q_fb;
    logic [W-1:0] bank_q;
    logic [W-1:0] force_mask;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         busy;
    logic         done;
    logic         err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] tj [TR];
    logic [W-1:0] tk [TR];
    logic [W-1:0] tq [TR];
    logic         tdone [TR];
    logic         terr [TR];
    logic         tbusy [TR];
    logic         trdy [TR];

    typedef struct {
        string       nm;
        logic [31:0] got;
        logic [31:0] exp;
    } chk_t;

    always #5 clk = ~clk;

    assign q_fb = bank_q & ~force_mask;

    jk_bank_driver #(.WIDTH(W), .MAX_RETRY(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .q_fb      (q_fb),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    for (genvar gi = 0; gi < W; gi++) begin : g_bank
        jk_flipflop u_ff (
            .clk   (clk),
            .reset (reset),
            .j_i   (j[gi]),
            .k_i   (k[gi]),
            .q_o   (bank_q[gi])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic record(input int c);
        tj[c]    = j;
        tk[c]    = k;
        tq[c]    = q_fb;
        tdone[c] = done;
        terr[c]  = err;
        tbusy[c] = busy;
        trdy[c]  = req_ready;
    endtask

    // Presents one request, waits (bounded) for acceptance, and traces cycles 0..TR-1.
    task automatic run_req(input logic [1:0] op, input logic [W-1:0] data, output bit ok);
        ok        = 1'b0;
        req_op    = op;
        req_data  = data;
        req_valid = 1'b1;
        for (int w = 0; w < 20 && !ok; w++) begin
            if (req_ready) ok = 1'b1;
            else step();
        end
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        record(0);
        step();
        req_valid = 1'b0;
        for (int c = 1; c < TR; c++) begin
            record(c);
            if (c < TR - 1) step();
        end
    endtask

    task automatic test_reset();
        chk_t cq[$];
        reset     = 1'b1;
        req_valid = 1'b0;
        step();
        step();
        cq.push_back('{"reset_j", 32'(j), 32'h0});
        cq.push_back('{"reset_k", 32'(k), 32'h0});
        cq.push_back('{"reset_busy", 32'(busy), 32'h0});
        cq.push_back('{"reset_done_err", 32'({done, err}), 32'h0});
        cq.push_back('{"reset_ready_low", 32'(req_ready), 32'h0});
        reset = 1'b0;
        #1;
        cq.push_back('{"reset_ready_after", 32'(req_ready), 32'h1});
        cq.push_back('{"reset_bank", 32'(bank_q), 32'h0});
        foreach (cq[i]) begin
            n_checks++;
            if (cq[i].got !== cq[i].exp) $display("FAIL %s: got 0x%0h want 0x%0h", cq[i].nm, cq[i].got, cq[i].exp);
            else n_pass++;
        end
    endtask

    task automatic test_load();
        chk_t cq[$];
        bit   ok;
        int   errs;
        run_req(2'b00, 8'h0F, ok);
        run_req(2'b00, 8'hF0, ok);
        errs = 0;
        for (int c = 0; c < TR; c++) errs += int'(terr[c]);
        cq.push_back('{"load_accept", 32'(ok), 32'h1});
        cq.push_back('{"load_j_drive", 32'(tj[1]), 32'hF0});
        cq.push_back('{"load_k_drive", 32'(tk[1]), 32'h0F});
        cq.push_back('{"load_jk_verify", 32'({tj[2], tk[2]}), 32'h0});
        cq.push_back('{"load_q_verify", 32'(tq[2]), 32'hF0});
        cq.push_back('{"load_done_c2", 32'(tdone[2]), 32'h0});
        cq.push_back('{"load_done_c3", 32'(tdone[3]), 32'h1});
        cq.push_back('{"load_done_c4", 32'(tdone[4]), 32'h0});
        cq.push_back('{"load_err_count", 32'(errs), 32'h0});
        cq.push_back('{"load_busy_c1", 32'(tbusy[1]), 32'h1});
        cq.push_back('{"load_ready_c3", 32'(trdy[3]), 32'h0});
        cq.push_back('{"load_ready_c4", 32'(trdy[4]), 32'h1});
        foreach (cq[i]) begin
            n_checks++;
            if (cq[i].got !== cq[i].exp) $display("FAIL %s: got 0x%0h want 0x%0h", cq[i].nm, cq[i].got, cq[i].exp);
            else n_pass++;
        end
    endtask

    task automatic test_set_clr();
        chk_t cq[$];
        bit   ok;
        run_req(2'b00, 8'h00, ok);
        run_req(2'b01, 8'h81, ok);
        cq.push_back('{"set_j", 32'(tj[1]), 32'h81});
        cq.push_back('{"set_k", 32'(tk[1]), 32'h00});
        cq.push_back('{"set_q", 32'(tq[2]), 32'h81});
        cq.push_back('{"set_done", 32'(tdone[3]), 32'h1});
        run_req(2'b10, 8'h01, ok);
        cq.push_back('{"clr_j", 32'(tj[1]), 32'h00});
        cq.push_back('{"clr_k", 32'(tk[1]), 32'h01});
        cq.push_back('{"clr_q", 32'(tq[2]), 32'h80});
        cq.push_back('{"clr_done", 32'(tdone[3]), 32'h1});
        foreach (cq[i]) begin
            n_checks++;
            if (cq[i].got !== cq[i].exp) $display("FAIL %s: got 0x%0h want 0x%0h", cq[i].nm, cq[i].got, cq[i].exp);
            else n_pass++;
        end
    endtask

    task automatic test_toggle();
        chk_t         cq[$];
        bit           ok;
        int           active;
        logic [W-1:0] any_jk;
        run_req(2'b00, 8'h5A, ok);
        run_req(2'b11, 8'hFF, ok);
        active = 0;
        for (int c = 0; c < TR; c++) if ((tj[c] | tk[c]) != '0) active++;
        cq.push_back('{"tog_j", 32'(tj[1]), 32'hFF});
        cq.push_back('{"tog_k", 32'(tk[1]), 32'hFF});
        cq.push_back('{"tog_active_cycles", 32'(active), 32'd1});
        cq.push_back('{"tog_q", 32'(tq[2]), 32'hA5});
        cq.push_back('{"tog_done", 32'(tdone[3]), 32'h1});
        run_req(2'b11, 8'h00, ok);
        any_jk = '0;
        for (int c = 0; c < TR; c++) any_jk |= tj[c] | tk[c];
        cq.push_back('{"tog0_jk_zero", 32'(any_jk), 32'h0});
        cq.push_back('{"tog0_q", 32'(tq[2]), 32'hA5});
        cq.push_back('{"tog0_done", 32'(tdone[3]), 32'h1});
        cq.push_back('{"tog0_bank", 32'(bank_q), 32'hA5});
        foreach (cq[i]) begin
            n_checks++;
            if (cq[i].got !== cq[i].exp) $display("FAIL %s: got 0x%0h want 0x%0h", cq[i].nm, cq[i].got, cq[i].exp);
            else n_pass++;
        end
    endtask

    task automatic test_retry();
        chk_t cq[$];
        bit   ok;
        int   drives;
        int   dones;
        run_req(2'b00, 8'h00, ok);
        force_mask = 8'h08;
        #1;
        run_req(2'b00, 8'h08, ok);
        drives = 0;
        dones  = 0;
        for (int c = 0; c < TR; c++) begin
            if (tj[c] == 8'h08) drives++;
            dones += int'(tdone[c]);
        end
        cq.push_back('{"retry_accept", 32'(ok), 32'h1});
        cq.push_back('{"retry_j_c1", 32'(tj[1]), 32'h08});
        cq.push_back('{"retry_j_c3", 32'(tj[3]), 32'h08});
        cq.push_back('{"retry_j_c5", 32'(tj[5]), 32'h08});
        cq.push_back('{"retry_drive_count", 32'(drives), 32'd3});
        cq.push_back('{"retry_err_c6", 32'(terr[6]), 32'h0});
        cq.push_back('{"retry_err_c7", 32'(terr[7]), 32'h1});
        cq.push_back('{"retry_err_c8", 32'(terr[8]), 32'h0});
        cq.push_back('{"retry_done_count", 32'(dones), 32'd0});
        cq.push_back('{"retry_ready_c7", 32'(trdy[7]), 32'h0});
        cq.push_back('{"retry_ready_c8", 32'(trdy[8]), 32'h1});
        force_mask = 8'h00;
        #1;
        cq.push_back('{"retry_bank_after", 32'(q_fb), 32'h08});
        foreach (cq[i]) begin
            n_checks++;
            if (cq[i].got !== cq[i].exp) $display("FAIL %s: got 0x%0h want 0x%0h", cq[i].nm, cq[i].got, cq[i].exp);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        chk_t cq[$];
        bit   ok;
        int   first_rdy;
        int   dones;
        ok        = 1'b0;
        req_op    = 2'b00;
        req_data  = 8'h11;
        req_valid = 1'b1;
        for (int w = 0; w < 20 && !ok; w++) begin
            if (req_ready) ok = 1'b1;
            else step();
        end
        record(0);
        step();
        req_data = 8'h22;
        for (int c = 1; c < 13; c++) begin
            record(c);
            if (c == 5) req_valid = 1'b0;
            step();
        end
        req_valid = 1'b0;
        first_rdy = -1;
        dones     = 0;
        for (int c = 1; c < 13; c++) begin
            if (trdy[c] && first_rdy < 0) first_rdy = c;
            dones += int'(tdone[c]);
        end
        cq.push_back('{"b2b_accept", 32'(ok), 32'h1});
        cq.push_back('{"b2b_second_ready", 32'(first_rdy), 32'd4});
        cq.push_back('{"b2b_q_first", 32'(tq[2]), 32'h11});
        cq.push_back('{"b2b_done_c3", 32'(tdone[3]), 32'h1});
        cq.push_back('{"b2b_j_second", 32'(tj[5]), 32'h22});
        cq.push_back('{"b2b_k_second", 32'(tk[5]), 32'h11});
        cq.push_back('{"b2b_q_second", 32'(tq[6]), 32'h22});
        cq.push_back('{"b2b_done_c7", 32'(tdone[7]), 32'h1});
        cq.push_back('{"b2b_done_count", 32'(dones), 32'd2});
        foreach (cq[i]) begin
            n_checks++;
            if (cq[i].got !== cq[i].exp) $display("FAIL %s: got 0x%0h want 0x%0h", cq[i].nm, cq[i].got, cq[i].exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        chk_t cq[$];
        bit   ok;
        logic resp_seen;
        run_req(2'b00, 8'h00, ok);
        ok        = 1'b0;
        req_op    = 2'b00;
        req_data  = 8'hFF;
        req_valid = 1'b1;
        for (int w = 0; w < 20 && !ok; w++) begin
            if (req_ready) ok = 1'b1;
            else step();
        end
        step();
        req_valid = 1'b0;
        cq.push_back('{"rmid_j_drive", 32'(j), 32'hFF});
        reset = 1'b1;
        step();
        cq.push_back('{"rmid_jk_after", 32'({j, k}), 32'h0});
        cq.push_back('{"rmid_busy", 32'(busy), 32'h0});
        cq.push_back('{"rmid_ready_in_reset", 32'(req_ready), 32'h0});
        resp_seen = done | err;
        reset     = 1'b0;
        step();
        cq.push_back('{"rmid_ready_after", 32'(req_ready), 32'h1});
        for (int c = 0; c < 5; c++) begin
            resp_seen |= done | err;
            step();
        end
        cq.push_back('{"rmid_no_resp", 32'(resp_seen), 32'h0});
        cq.push_back('{"rmid_bank", 32'(bank_q), 32'h0});
        foreach (cq[i]) begin
            n_checks++;
            if (cq[i].got !== cq[i].exp) $display("FAIL %s: got 0x%0h want 0x%0h", cq[i].nm, cq[i].got, cq[i].exp);
            else n_pass++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_data   = '0;
        force_mask = '0;
        test_reset();
        test_load();
        test_set_clr();
        test_toggle();
        test_retry();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
